// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_pkg
//  Description : Shared defaults, constants and helpers for the general
//                register file with pending-write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int PEND_W_DEF   = 2;
  localparam int REG_ZERO     = 0;

  // Widest index / packed read bus the slicing helper handles.
  localparam int ADDR_MAX     = 16;
  localparam int ADDR_BUS_MAX = 64;

  // Extract read-port k's index (aw bits wide) from the zero-extended
  // packed read-address bus; upper result bits are returned as zero.
  function automatic logic [ADDR_MAX-1:0] port_slice(
    input logic [ADDR_BUS_MAX-1:0] bus,
    input int                      k,
    input int                      aw
  );
    logic [ADDR_MAX-1:0] res;
    logic [5:0]          idx;
    res = '0;
    for (int b = 0; b < ADDR_MAX; b++) begin
      if (b < aw) begin
        idx    = 6'(k * aw + b);
        res[b] = bus[idx];
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grf_pend_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : grf_pend_ctr
//  Description : Saturating up/down pending-write counter for one register.
//                Flush clears it; o_err pulses on an overflowing increment or
//                an underflowing decrement (suppressed during flush).
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PEND_W-1:0] o_cnt,
  output logic              o_err
);

  localparam logic [PEND_W-1:0] C_CNT_MAX = '1;

  logic [PEND_W-1:0] r_cnt;
  logic              w_full;
  logic              w_empty;
  logic              w_inc_ok;
  logic              w_dec_ok;

  assign w_full   = (r_cnt == C_CNT_MAX);
  assign w_empty  = (r_cnt == '0);
  assign w_inc_ok = i_inc && !w_full;
  assign w_dec_ok = i_dec && !w_empty;

  // Overflowing alloc or writeback with nothing pending, unless flushing.
  assign o_err = !i_flush && ((i_inc && w_full) || (i_dec && w_empty));
  assign o_cnt = r_cnt;

  // Counter update: flush dominates, otherwise net of accepted inc/dec.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      case ({w_inc_ok, w_dec_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/grf_sb.sv
`default_nettype none
// ============================================================================
//  Module      : grf_sb
//  Description : General register file, NUM_RD combinational read ports with
//                same-cycle write bypass, one write port, per-register
//                pending-write scoreboard, sticky error and writeback trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_sb
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_alloc_en,
  input  logic [ADDR_W-1:0]        i_alloc_addr,
  output logic                     o_alloc_ready,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [31:0]              i_wr_pc,
  input  logic                     i_flush,
  output logic                     o_wb_valid,
  output logic [31:0]              o_wb_pc,
  output logic [ADDR_W-1:0]        o_wb_addr,
  output logic [DATA_W-1:0]        o_wb_data,
  output logic                     o_err
);

  localparam int                C_DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO    = ADDR_W'(REG_ZERO);
  localparam logic [PEND_W-1:0] C_CNT_MAX = '1;

  logic [DATA_W-1:0]       r_regs [C_DEPTH];
  logic [PEND_W-1:0]       w_cnt  [C_DEPTH];
  logic [C_DEPTH-1:0]      w_err_vec;
  logic [ADDR_BUS_MAX-1:0] w_rd_bus;
  logic                    w_wr_nz;
  logic                    r_err;
  logic                    r_wb_valid;
  logic [31:0]             r_wb_pc;
  logic [ADDR_W-1:0]       r_wb_addr;
  logic [DATA_W-1:0]       r_wb_data;

  assign w_wr_nz  = i_wr_en && (i_wr_addr != C_ZERO);
  assign w_rd_bus = ADDR_BUS_MAX'(i_rd_addr);

  // Register 0 has no counter and never reports an error.
  assign w_cnt[0]     = '0;
  assign w_err_vec[0] = 1'b0;

  generate
    for (genvar r = 1; r < C_DEPTH; r++) begin : g_ctr
      grf_pend_ctr #(
        .PEND_W (PEND_W)
      ) u_ctr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_inc   (i_alloc_en && (i_alloc_addr == ADDR_W'(r))),
        .i_dec   (i_wr_en && (i_wr_addr == ADDR_W'(r))),
        .o_cnt   (w_cnt[r]),
        .o_err   (w_err_vec[r])
      );
    end
  endgenerate

  // Address 0 always sees a zero counter, so it is always ready.
  assign o_alloc_ready = (w_cnt[i_alloc_addr] != C_CNT_MAX);

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_MAX-1:0] w_ra_full;
      logic [ADDR_W-1:0]   w_ra;
      logic                w_hit;
      logic [PEND_W-1:0]   w_rem;
      logic                w_unused_ra;

      assign w_ra_full   = port_slice(w_rd_bus, k, ADDR_W);
      assign w_ra        = w_ra_full[ADDR_W-1:0];
      assign w_unused_ra = ^w_ra_full[ADDR_MAX-1:ADDR_W];
      assign w_hit       = i_wr_en && (i_wr_addr == w_ra);
      // Pending count with the retiring write already removed.
      assign w_rem       = w_cnt[w_ra] - PEND_W'(w_hit);

      assign o_rd_data[k*DATA_W +: DATA_W] =
          (w_ra == C_ZERO) ? '0 :
          w_hit            ? i_wr_data :
                             r_regs[w_ra];
      assign o_rd_busy[k] = (w_ra != C_ZERO) && (w_rem != '0);
    end
  endgenerate

  // Storage: writes to register 0 are dropped so it stays zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_nz) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Sticky error: any counter error pulse sets it until reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (|w_err_vec) begin
      r_err <= 1'b1;
    end
  end

  // Writeback trace: valid every edge, payload held when no write retires.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wb_valid <= 1'b0;
      r_wb_pc    <= '0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_wr_nz;
      if (w_wr_nz) begin
        r_wb_pc   <= i_wr_pc;
        r_wb_addr <= i_wr_addr;
        r_wb_data <= i_wr_data;
      end
    end
  end

  assign o_err      = r_err;
  assign o_wb_valid = r_wb_valid;
  assign o_wb_pc    = r_wb_pc;
  assign o_wb_addr  = r_wb_addr;
  assign o_wb_data  = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_grf_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_sb
//  Description : Self-checking bench for grf_sb (directed + random traffic
//                against a behavioural register/scoreboard model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int PW    = 2;
  localparam int DEPTH = 32;
  localparam int MAXC  = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_ready;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [31:0]      wr_pc;
  logic             flush;
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             err;

  grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .o_alloc_ready(alloc_ready),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_pc      (wr_pc),
    .i_flush      (flush),
    .o_wb_valid   (wb_valid),
    .o_wb_pc      (wb_pc),
    .o_wb_addr    (wb_addr),
    .o_wb_data    (wb_data),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] m_reg [DEPTH];
  int            m_cnt [DEPTH];
  logic          m_err;
  logic          m_wbv;
  logic [31:0]   m_wbpc;
  logic [AW-1:0] m_wbaddr;
  logic [DW-1:0] m_wbdata;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i] = '0;
      m_cnt[i] = 0;
    end
    m_err = 0; m_wbv = 0; m_wbpc = '0; m_wbaddr = '0; m_wbdata = '0;
  endfunction

  // One clock edge of the architectural rules, using the held inputs.
  function automatic void model_step();
    bit wnz, anz, inc_ok, dec_ok;
    wnz    = wr_en && (wr_addr != 0);
    anz    = alloc_en && (alloc_addr != 0);
    inc_ok = anz && (m_cnt[alloc_addr] != MAXC);
    dec_ok = wnz && (m_cnt[wr_addr] != 0);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_cnt[i] = 0;
    end else begin
      if (anz && !inc_ok) m_err = 1;
      if (wnz && !dec_ok) m_err = 1;
      if (inc_ok) m_cnt[alloc_addr] = m_cnt[alloc_addr] + 1;
      if (dec_ok) m_cnt[wr_addr]    = m_cnt[wr_addr] - 1;
    end
    if (wnz) begin
      m_reg[wr_addr] = wr_data;
      m_wbpc = wr_pc; m_wbaddr = wr_addr; m_wbdata = wr_data;
    end
    m_wbv = wnz;
  endfunction

  task automatic check_comb();
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      int            rem;
      a   = rd_addr[k*AW +: AW];
      ed  = (a == 0) ? '0 : ((wr_en && wr_addr == a) ? wr_data : m_reg[a]);
      rem = m_cnt[a] - ((wr_en && wr_addr == a) ? 1 : 0);
      chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], ed);
      chk($sformatf("rd_busy[%0d]", k), rd_busy[k], (a != 0) && (rem != 0));
    end
    chk("alloc_ready", alloc_ready, m_cnt[alloc_addr] != MAXC);
  endtask

  task automatic check_regd();
    chk("wb_valid", wb_valid, m_wbv);
    chk("wb_pc",    wb_pc,    m_wbpc);
    chk("wb_addr",  wb_addr,  m_wbaddr);
    chk("wb_data",  wb_data,  m_wbdata);
    chk("err",      err,      m_err);
  endtask

  task automatic drive(input int r0, input int r1, input bit ae, input int aa,
                       input bit we, input int wa, input logic [31:0] wd,
                       input logic [31:0] pc, input bit fl);
    rd_addr    = {AW'(r1), AW'(r0)};
    alloc_en   = ae; alloc_addr = AW'(aa);
    wr_en      = we; wr_addr    = AW'(wa);
    wr_data    = wd; wr_pc      = pc;
    flush      = fl;
  endtask

  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_step();
    #1;
    check_regd();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    drive(5, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #12 reset = 1'b0;

    // Reset state
    #1;
    chk("reset_rd5",   rd_data[31:0], 32'h0);
    chk("reset_rd0",   rd_data[63:32], 32'h0);
    chk("reset_busy",  rd_busy, 2'b00);
    chk("reset_err",   err, 1'b0);
    cycle();

    // Write with same-cycle bypass, then trace
    @(posedge clk); #1;
    drive(3, 0, 0, 0, 1, 3, 32'h1234ABCD, 32'h0000_0400, 0);
    #1 chk("bypass_r3", rd_data[31:0], 32'h1234ABCD);
    cycle();
    chk("trace_valid", wb_valid, 1'b1);
    chk("trace_pc",    wb_pc,    32'h0000_0400);
    chk("trace_addr",  wb_addr,  5'd3);
    chk("trace_data",  wb_data,  32'h1234ABCD);

    // Scoreboard on r7
    drive(7, 0, 1, 7, 0, 0, 0, 0, 0); cycle();
    cycle();
    drive(7, 0, 0, 0, 1, 7, 32'h11, 32'h10, 0);
    #1 chk("r7_busy_first_wr", rd_busy[0], 1'b1);
    cycle();
    drive(7, 0, 0, 0, 1, 7, 32'h22, 32'h14, 0);
    #1 chk("r7_busy_last_wr", rd_busy[0], 1'b0);
    chk("r7_bypass", rd_data[31:0], 32'h22);
    cycle();

    // Saturation on r9
    drive(9, 0, 1, 9, 0, 0, 0, 0, 0);
    cycle(); cycle(); cycle();
    #1 chk("r9_not_ready", alloc_ready, 1'b0);
    cycle();
    chk("r9_overflow_err", err, 1'b1);
    drive(9, 0, 1, 9, 1, 9, 32'h99, 32'h20, 0); cycle();
    drive(9, 0, 0, 9, 0, 0, 0, 0, 0);
    #1 chk("r9_ready_after", alloc_ready, 1'b1);
    chk("r9_busy_after", rd_busy[0], 1'b1);
    cycle();

    // Flush with alloc in the same cycle
    do_reset();
    drive(4, 0, 1, 4, 0, 0, 0, 0, 0); cycle(); cycle();
    drive(4, 0, 1, 4, 0, 0, 0, 0, 1); cycle();
    drive(4, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("flush_busy_r4", rd_busy[0], 1'b0);
    chk("flush_err", err, 1'b0);
    cycle();
    drive(4, 0, 0, 0, 1, 4, 32'hCAFE, 32'h30, 0); cycle();
    chk("underflow_err", err, 1'b1);
    drive(4, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // Register 0 is inert
    do_reset();
    drive(0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'h40, 0);
    #1 chk("r0_read", rd_data, 64'h0);
    chk("r0_busy", rd_busy, 2'b00);
    cycle();
    chk("r0_wb_valid", wb_valid, 1'b0);
    chk("r0_err", err, 1'b0);

    // Asynchronous reset mid-cycle
    drive(3, 5, 0, 0, 1, 3, 32'hAAAA_0003, 32'h50, 0); cycle();
    drive(3, 5, 1, 6, 1, 5, 32'hBBBB_0005, 32'h54, 0); cycle();
    drive(3, 5, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_rd", rd_data, 64'h0);
    chk("arst_busy", rd_busy, 2'b00);
    chk("arst_wbv", wb_valid, 1'b0);
    chk("arst_wbpc", wb_pc, 32'h0);
    chk("arst_wbdata", wb_data, 32'h0);
    chk("arst_err", err, 1'b0);
    #1 reset = 1'b0;
    model_reset();
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7),
            ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
            ($urandom_range(0, 1) == 1), $urandom_range(0, 7),
            $urandom, $urandom, ($urandom_range(0, 19) == 0));
      cycle();
      if (n % 150 == 149) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised general register file for the pipelined CPU, with NUM_RD read ports and one write port.
- Same-cycle write-to-read bypass.
- Per-register pending-write scoreboard: a counter per register tracks in-flight producers between issue (alloc) and writeback, so the hazard unit can stall on rd_busy instead of decoding T_new per stage.
- Sits between the D-stage (read, alloc) and the W-stage (writeback, trace).

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- PEND_W, 2, pending-counter width per register; max 2**PEND_W-1 in-flight writes per register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read indices; port k is slice k.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- rd_busy  out  NUM_RD  register of port k has an outstanding producer.
- alloc_en  in  1  issue: mark alloc_addr as having one more pending write.
- alloc_addr  in  ADDR_W  destination being issued.
- alloc_ready  out  1  alloc_addr counter below max; the issuer must not alloc when low.
- wr_en  in  1  writeback valid.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback value.
- wr_pc  in  32  PC of the retiring instruction (trace only).
- flush  in  1  clear all pending counters (pipeline flush).
- wb_valid  out  1  registered trace: a nonzero register was written last cycle.
- wb_pc  out  32  registered trace PC.
- wb_addr  out  ADDR_W  registered trace index.
- wb_data  out  DATA_W  registered trace data.
- err  out  1  sticky: alloc overflow, or writeback with zero pending.

Behaviour:
- Reset (async, any time including mid-operation):
  - All registers 0, all counters 0.
  - wb_valid=0, wb_pc=0, wb_addr=0, wb_data=0, err=0.
  - Reads during reset are combinational on the cleared state.
- Register 0:
  - Reads always return 0 and rd_busy is always 0.
  - Writes are ignored and produce no trace.
  - Allocs are ignored; alloc_ready=1 when alloc_addr=0.
  - No err from register 0 activity.
- Read (combinational, 0 latency):
  - rd_data[k] = wr_data if wr_en && wr_addr==rd_addr[k] && wr_addr!=0; otherwise the stored value.
- rd_busy[k] (combinational):
  - Equals (cnt[a] - (wr_en && wr_addr==a ? 1 : 0)) != 0, where a = rd_addr[k].
  - The retiring write is therefore already excluded.
  - A same-cycle alloc does not affect rd_busy until the next cycle.
- Write: on a clk edge with wr_en && wr_addr!=0, reg[wr_addr] <= wr_data.
- Counters, per register r != 0, in priority order:
  - flush=1: cnt <= 0, for all r. No err from writes or allocs in that cycle; the data write still lands.
  - Otherwise inc = alloc_en && alloc_addr==r && cnt!=max, and dec = wr_en && wr_addr==r && cnt!=0.
  - cnt <= cnt + inc - dec. A simultaneous inc and dec leaves cnt unchanged; at cnt=max, alloc+write gives max-1.
- err sets on an edge (flush=0) when:
  - alloc_en && alloc_addr!=0 && cnt==max (the alloc is dropped), or
  - wr_en && wr_addr!=0 && cnt==0 (the write is still performed).
  - err clears only on reset.
- alloc_ready: combinational, cnt[alloc_addr] != max.
- Trace: one-cycle latency. On each edge wb_valid <= wr_en && wr_addr!=0; wb_pc/wb_addr/wb_data load only when that is 1, otherwise they hold.

Decomposition:
- grf_pkg holds:
  - Defaults DATA_W, ADDR_W, PEND_W.
  - Constant REG_ZERO = 0.
  - A function slicing the packed read port k.
- Sub-module grf_pend_ctr: one saturating up/down counter with flush, inc, dec and an err pulse. Instantiated per register 1..2**ADDR_W-1 via generate. The top level ORs the err pulses into the sticky err.

Test Plan:
- Reset, then read r5 and r0 -> rd_data=0, rd_busy=0, err=0.
- Write r3=0x1234ABCD with rd_addr port0=3 in the same cycle -> port0 reads 0x1234ABCD combinationally. Next cycle: wb_valid=1, wb_pc=wr_pc, wb_addr=3, wb_data=0x1234ABCD.
- Scoreboard sequence on r7:
  - alloc r7 twice -> rd_busy=1, cnt=2.
  - Write r7=0x11 -> rd_busy still 1.
  - Second write r7=0x22 -> rd_busy=0 in the same cycle; reads 0x22.
- Saturation on r9 (PEND_W=2):
  - Three allocs -> alloc_ready=0.
  - Fourth alloc -> dropped, err=1.
  - Simultaneous alloc+write on r9 at cnt=3 -> cnt=2.
- Flush with r4 cnt=2 and alloc r4 in the same cycle -> next cycle rd_busy(r4)=0, err=0. A following write r4 with no pending -> data written, err=1.
- Write r0=0xFFFFFFFF and alloc r0 -> reads 0, rd_busy=0, wb_valid=0, err=0.
- Assert reset asynchronously mid-cycle after writes -> all outputs 0 immediately, without waiting for a clk edge.
